// File: rtl/pipe_reg_chain.sv
// Rigid in-order pipeline register chain: per-stage valid, stall/bubble insertion,
// per-stage flush, output backpressure and destination-tag hazard lookup.
module pipe_reg_chain #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int TAG_W = 5,
    parameter int CNT_W = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [0:WIDTH-1]           in_data,
    input  logic [0:TAG_W-1]           in_tag,
    input  logic                       in_we,
    output logic                       in_ready,
    input  logic [0:DEPTH-1]           stall_req,
    input  logic [0:DEPTH-1]           flush,
    output logic                       out_valid,
    output logic [0:WIDTH-1]           out_data,
    output logic [0:TAG_W-1]           out_tag,
    output logic                       out_we,
    input  logic                       out_ready,
    output logic [0:DEPTH-1]           stage_valid,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    input  logic [0:TAG_W-1]           hz_tag,
    output logic [0:DEPTH-1]           hz_hit,
    output logic [0:CNT_W-1]           stall_cycles
);
    localparam int OCC_W = $clog2(DEPTH+1);

    logic [0:DEPTH-1] r_valid;
    logic [0:WIDTH-1] r_data [DEPTH];
    logic [0:TAG_W-1] r_tag  [DEPTH];
    logic [0:DEPTH-1] r_we;
    logic [0:CNT_W-1] r_stall_cnt;

    logic [0:DEPTH-1] w_hold;
    logic [OCC_W-1:0] w_occ;
    logic [0:DEPTH-1] w_hit;

    // A hold anywhere downstream freezes every younger stage (no bubble collapsing).
    always_comb begin
        logic v_acc;
        w_hold = '0;
        v_acc  = r_valid[DEPTH-1] & ~out_ready;
        for (int k = DEPTH-1; k >= 0; k--) begin
            v_acc     = v_acc | stall_req[k];
            w_hold[k] = v_acc;
        end
    end

    always_comb begin
        w_occ = '0;
        w_hit = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_occ    = w_occ + OCC_W'(r_valid[k]);
            w_hit[k] = r_valid[k] & r_we[k] & (r_tag[k] == hz_tag) & (hz_tag != '0);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid     <= '0;
            r_we        <= '0;
            r_stall_cnt <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_data[k] <= '0;
                r_tag[k]  <= '0;
            end
        end else begin
            if (!in_ready && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);

            if (flush[0]) begin
                r_valid[0] <= 1'b0;
                r_data[0]  <= '0;
                r_tag[0]   <= '0;
                r_we[0]    <= 1'b0;
            end else if (!w_hold[0]) begin
                r_valid[0] <= in_valid;
                r_data[0]  <= in_data;
                r_tag[0]   <= in_tag;
                r_we[0]    <= in_we;
            end

            for (int k = 1; k < DEPTH; k++) begin
                if (flush[k]) begin
                    r_valid[k] <= 1'b0;
                    r_data[k]  <= '0;
                    r_tag[k]   <= '0;
                    r_we[k]    <= 1'b0;
                end else if (!w_hold[k]) begin
                    // Upstream frozen but this stage free: it drains into a bubble.
                    if (w_hold[k-1]) begin
                        r_valid[k] <= 1'b0;
                        r_data[k]  <= '0;
                        r_tag[k]   <= '0;
                        r_we[k]    <= 1'b0;
                    end else begin
                        r_valid[k] <= r_valid[k-1];
                        r_data[k]  <= r_data[k-1];
                        r_tag[k]   <= r_tag[k-1];
                        r_we[k]    <= r_we[k-1];
                    end
                end
            end
        end
    end

    assign in_ready     = ~w_hold[0];
    assign out_valid    = r_valid[DEPTH-1];
    assign out_data     = r_data[DEPTH-1];
    assign out_tag      = r_tag[DEPTH-1];
    assign out_we       = r_we[DEPTH-1] & r_valid[DEPTH-1];
    assign stage_valid  = r_valid;
    assign occupancy    = w_occ;
    assign hz_hit       = w_hit;
    assign stall_cycles = r_stall_cnt;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Bench for pipe_reg_chain: directed scenarios plus random traffic, all checked
// every cycle against an entry-level model of the pipeline.
module tb_pipe_reg_chain;
    localparam int WIDTH   = 32;
    localparam int DEPTH   = 4;
    localparam int TAG_W   = 5;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                       clock = 1'b0;
    logic                       reset;
    logic                       in_valid;
    logic [0:WIDTH-1]           in_data;
    logic [0:TAG_W-1]           in_tag;
    logic                       in_we;
    logic                       in_ready;
    logic [0:DEPTH-1]           stall_req;
    logic [0:DEPTH-1]           flush;
    logic                       out_valid;
    logic [0:WIDTH-1]           out_data;
    logic [0:TAG_W-1]           out_tag;
    logic                       out_we;
    logic                       out_ready;
    logic [0:DEPTH-1]           stage_valid;
    logic [$clog2(DEPTH+1)-1:0] occupancy;
    logic [0:TAG_W-1]           hz_tag;
    logic [0:DEPTH-1]           hz_hit;
    logic [0:CNT_W-1]           stall_cycles;

    pipe_reg_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_data(in_data), .in_tag(in_tag), .in_we(in_we),
        .in_ready(in_ready), .stall_req(stall_req), .flush(flush),
        .out_valid(out_valid), .out_data(out_data), .out_tag(out_tag), .out_we(out_we),
        .out_ready(out_ready), .stage_valid(stage_valid), .occupancy(occupancy),
        .hz_tag(hz_tag), .hz_hit(hz_hit), .stall_cycles(stall_cycles)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: one entry record per pipeline position, oldest at DEPTH-1.
    bit               m_v [DEPTH];
    logic [WIDTH-1:0] m_d [DEPTH];
    logic [TAG_W-1:0] m_t [DEPTH];
    bit               m_w [DEPTH];
    int               m_cnt;

    int got[$];
    int exp_seq[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Highest stage that cannot move this cycle; everything at or below it freezes.
    function automatic int front_idx();
        int f = -1;
        for (int k = 0; k < DEPTH; k++) if (stall_req[k]) f = k;
        if (m_v[DEPTH-1] && !out_ready) f = DEPTH-1;
        return f;
    endfunction

    task automatic check_all();
        int f;
        int occ;
        f   = front_idx();
        occ = 0;
        chk("in_ready", in_ready, f < 0);
        chk("out_valid", out_valid, m_v[DEPTH-1]);
        chk("out_data", out_data, m_d[DEPTH-1]);
        chk("out_tag", out_tag, m_t[DEPTH-1]);
        chk("out_we", out_we, m_w[DEPTH-1] & m_v[DEPTH-1]);
        for (int k = 0; k < DEPTH; k++) begin
            if (m_v[k]) occ++;
            chk($sformatf("stage_valid[%0d]", k), stage_valid[k], m_v[k]);
            chk($sformatf("hz_hit[%0d]", k), hz_hit[k],
                m_v[k] && m_w[k] && (m_t[k] == hz_tag) && (hz_tag != 0));
        end
        chk("occupancy", occupancy, occ);
        chk("stall_cycles", stall_cycles, m_cnt);
    endtask

    task automatic model_edge();
        int f;
        f = front_idx();
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                m_v[k] = 0; m_d[k] = '0; m_t[k] = '0; m_w[k] = 0;
            end
            m_cnt = 0;
        end else begin
            if (f >= 0 && m_cnt < CNT_MAX) m_cnt++;
            for (int k = DEPTH-1; k >= 0; k--) begin
                if (k <= f) begin
                    m_v[k] = m_v[k];
                end else if (f >= 0 && k == f + 1) begin
                    m_v[k] = 0; m_d[k] = '0; m_t[k] = '0; m_w[k] = 0;
                end else if (k == 0) begin
                    m_v[0] = in_valid; m_d[0] = in_data; m_t[0] = in_tag; m_w[0] = in_we;
                end else begin
                    m_v[k] = m_v[k-1]; m_d[k] = m_d[k-1]; m_t[k] = m_t[k-1]; m_w[k] = m_w[k-1];
                end
            end
            for (int k = 0; k < DEPTH; k++) if (flush[k]) begin
                m_v[k] = 0; m_d[k] = '0; m_t[k] = '0; m_w[k] = 0;
            end
        end
    endtask

    task automatic cycle();
        #1;
        check_all();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        in_data   = '0;
        in_tag    = '0;
        in_we     = 1'b0;
        stall_req = '0;
        flush     = '0;
        out_ready = 1'b1;
        hz_tag    = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    task automatic feed(input int d);
        in_valid = 1'b1;
        in_data  = WIDTH'(d);
        in_tag   = TAG_W'(d);
        in_we    = 1'b1;
        cycle();
        in_valid = 1'b0;
    endtask

    function automatic int out_val();
        return out_valid ? int'(out_data) : -1;
    endfunction

    task automatic cmp_seq(input string name);
        chk({name, "_len"}, got.size(), exp_seq.size());
        for (int i = 0; i < exp_seq.size() && i < got.size(); i++)
            chk($sformatf("%s_out%0d", name, i), got[i], exp_seq[i]);
    endtask

    initial begin
        int first_c;
        int last_c;
        int max_occ;

        idle_inputs();
        reset = 1'b1;
        @(posedge clock);
        model_edge();
        #1;
        reset = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_out_we", out_we, 0);
        chk("rst_stage_valid", stage_valid, 0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_hz_hit", hz_hit, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_stall_cycles", stall_cycles, 0);

        // Streaming 1..8 without stalls.
        do_reset();
        got.delete();
        first_c = -1; last_c = -1; max_occ = 0;
        for (int c = 0; c < 12; c++) begin
            in_valid = (c < 8);
            in_data  = WIDTH'(c + 1);
            in_tag   = TAG_W'(c + 1);
            in_we    = 1'b1;
            cycle();
            if (out_valid) begin
                got.push_back(int'(out_data));
                if (first_c < 0) first_c = c;
                last_c = c;
            end
            if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
        end
        exp_seq = '{1, 2, 3, 4, 5, 6, 7, 8};
        cmp_seq("stream");
        chk("stream_first_cycle", first_c, 3);
        chk("stream_last_cycle", last_c, 10);
        chk("stream_max_occ", max_occ, 4);
        chk("stream_stall_cycles", stall_cycles, 0);

        // stall_req[1] pulse of 2 cycles on a full pipe.
        do_reset();
        for (int c = 0; c < 4; c++) feed(10 + c);
        chk("stall_full_occ", occupancy, 4);
        got.delete();
        got.push_back(out_val());
        for (int c = 0; c < 5; c++) begin
            stall_req = (c < 2) ? 4'b0100 : 4'b0000;
            cycle();
            got.push_back(out_val());
        end
        stall_req = '0;
        exp_seq = '{10, 11, -1, -1, 12, 13};
        cmp_seq("stall1");
        chk("stall1_count", stall_cycles, 2);

        // Backpressure for 3 cycles with the pipe full.
        do_reset();
        for (int c = 0; c < 4; c++) feed(20 + c);
        got.delete();
        got.push_back(out_val());
        for (int c = 0; c < 7; c++) begin
            out_ready = (c >= 3);
            cycle();
            got.push_back(out_val());
        end
        exp_seq = '{20, 20, 20, 20, 21, 22, 23, -1};
        cmp_seq("bp");
        chk("bp_count", stall_cycles, 3);

        // Flush the two youngest stages while the whole pipe is held.
        do_reset();
        for (int c = 0; c < 4; c++) feed(30 + c);
        got.delete();
        got.push_back(out_val());
        out_ready = 1'b0;
        flush     = 4'b1100;
        cycle();
        flush = '0;
        chk("flush_stage_valid", stage_valid, 4'b0011);
        got.push_back(out_val());
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cycle();
            got.push_back(out_val());
        end
        exp_seq = '{30, 30, 31, -1, -1};
        cmp_seq("flush");

        // Hazard lookup on an entry parked in stage 2.
        do_reset();
        in_valid = 1'b1; in_data = 32'h55; in_tag = 5'd5; in_we = 1'b1;
        cycle();
        in_valid = 1'b0;
        cycle();
        cycle();
        hz_tag = 5'd5;
        #1 chk("hz_tag5", hz_hit, 4'b0010);
        hz_tag = 5'd6;
        #1 chk("hz_tag6", hz_hit, 0);
        hz_tag = 5'd0;
        #1 chk("hz_tag0", hz_hit, 0);
        do_reset();
        in_valid = 1'b1; in_data = 32'h56; in_tag = 5'd5; in_we = 1'b0;
        cycle();
        in_valid = 1'b0;
        cycle();
        cycle();
        hz_tag = 5'd5;
        #1 chk("hz_we0", hz_hit, 0);

        // Stall counter saturation.
        do_reset();
        stall_req = 4'b0001;
        for (int c = 0; c < 20; c++) cycle();
        stall_req = '0;
        chk("stall_saturate", stall_cycles, CNT_MAX);

        // Reset in the middle of traffic.
        do_reset();
        stall_req = 4'b0001;
        cycle();
        stall_req = '0;
        for (int c = 0; c < 3; c++) feed(40 + c);
        chk("mid_occ3", occupancy, 3);
        chk("mid_cnt1", stall_cycles, 1);
        reset = 1'b1; in_valid = 1'b1; in_data = 32'd99; stall_req = 4'b0010;
        cycle();
        reset = 1'b0; in_valid = 1'b0; stall_req = '0;
        #1;
        chk("mid_rst_occ", occupancy, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_stall_cycles", stall_cycles, 0);

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            reset     = ($urandom_range(0, 63) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            in_tag    = TAG_W'($urandom_range(0, 7));
            in_we     = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            hz_tag    = TAG_W'($urandom_range(0, 7));
            for (int k = 0; k < DEPTH; k++) begin
                stall_req[k] = ($urandom_range(0, 9) == 0);
                flush[k]     = ($urandom_range(0, 15) == 0);
            end
            cycle();
        end
        reset = 1'b0;
        idle_inputs();
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
